// File: rtl/pair_select_rr.sv
// Round-robin pair selector feeding an OUT_DEPTH-entry FIFO with valid/ready on both sides.
// Optional macro PAIR_SELECT_RR_STATS_EN adds saturating pop and full-stall counters.
module pair_select_rr #(
  parameter int NUM_IN    = 8,
  parameter int NB_W      = 64,
  parameter int PID_W     = 9,
  parameter int OUT_DEPTH = 4,
  localparam int SRC_W    = $clog2(NUM_IN),
  localparam int AW       = $clog2(OUT_DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_IN-1:0]              i_valid,
  output logic [NUM_IN-1:0]              o_grant,
  input  logic [NUM_IN-1:0][NB_W-1:0]    i_nb,
  input  logic [NUM_IN-1:0][PID_W-1:0]   i_home_parid,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [NB_W-1:0]                o_nb,
  output logic [PID_W-1:0]               o_home_parid,
  output logic [SRC_W-1:0]               o_src,
  output logic [CW-1:0]                  o_count
`ifdef PAIR_SELECT_RR_STATS_EN
  ,
  output logic [31:0]                    o_pair_count,
  output logic [31:0]                    o_stall_count
`endif
);

  localparam int EW = NB_W + PID_W + SRC_W;
  localparam logic [SRC_W:0] N_L = (SRC_W+1)'(NUM_IN);
  localparam logic [SRC_W-1:0] LAST = SRC_W'(NUM_IN - 1);
  localparam logic [CW-1:0] FULL_C = CW'(OUT_DEPTH);

  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_DEPTH-1:0][EW-1:0] mem_q;

  logic [SRC_W:0]   scan;
  logic [SRC_W-1:0] sel;
  logic             found;
  logic             full;
  logic             push;
  logic             pop;

  assign full = (cnt_q == FULL_C);

  // Scan ptr, ptr+1, ... and keep the first requester found.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    scan  = '0;
    for (int j = 0; j < NUM_IN; j++) begin
      scan = {1'b0, ptr_q} + (SRC_W+1)'(j);
      if (scan >= N_L) scan = scan - N_L;
      if (!found && i_valid[scan[SRC_W-1:0]]) begin
        found = 1'b1;
        sel   = scan[SRC_W-1:0];
      end
    end
  end

  assign push    = !rst && !full && found;
  assign o_grant = push ? (NUM_IN'(1) << sel) : '0;
  assign pop     = o_valid && i_ready;

  always_comb begin
    ptr_d = ptr_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = (sel == LAST) ? '0 : sel + 1'b1;
      wr_d  = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      mem_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push) mem_q[wr_q] <= {i_nb[sel], i_home_parid[sel], sel};
    end
  end

  assign o_valid = (cnt_q != '0);
  assign o_count = cnt_q;
  assign {o_nb, o_home_parid, o_src} = mem_q[rd_q];

`ifdef PAIR_SELECT_RR_STATS_EN
  logic [31:0] pair_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_q  <= '0;
      stall_q <= '0;
    end else begin
      if (pop && pair_q != '1) pair_q <= pair_q + 1'b1;
      if ((|i_valid) && full && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  assign o_pair_count  = pair_q;
  assign o_stall_count = stall_q;
`endif

endmodule
